// File: rtl/logic_lab_pkg.sv
// Shared definitions for the gate/ALU demonstrator: op encodings and op width.
package logic_lab_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ADD  = 3'd6,
    OP_SUB  = 3'd7
  } op_e;

endpackage

// File: rtl/logic_gate_lab_debounce.sv
// One-bit 2-flop synchroniser followed by a consecutive-cycle debounce filter.
module debounce #(
  parameter int unsigned DEB_CYCLES   = 240000,
  parameter logic        RST_VAL      = 1'b0,
  parameter logic        SYNC_RST_VAL = RST_VAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic synced,
  output logic stable
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);

  logic             meta;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= SYNC_RST_VAL;
      synced <= SYNC_RST_VAL;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

  // Any cycle where the synced value matches the accepted one restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= RST_VAL;
    end else if (synced == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
      stable <= synced;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/logic_gate_lab.sv
// Gate/ALU demonstrator: debounced switch operands combined by a key- or scan-stepped op,
// driving active-low LEDs.
module logic_gate_lab
  import logic_lab_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DEB_CYCLES  = 240000,
  parameter int unsigned SCAN_CYCLES = 12000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             key_n,
  input  logic             scan_en,
  output logic [WIDTH-1:0] led,
  output logic [OP_W-1:0]  op_led
);

  localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES);

  logic [WIDTH-1:0]  a_db;
  logic [WIDTH-1:0]  b_db;
  logic [WIDTH-1:0]  a_sync_unused;
  logic [WIDTH-1:0]  b_sync_unused;
  logic              scan_sync_unused;
  logic              key_db;
  logic              key_sync;
  logic              scan_db;

  logic              key_q;
  logic              armed;
  logic              press_c;
  logic              tick_c;
  logic [SCAN_W-1:0] scan_cnt;
  op_e               op;
  op_e               op_nxt_c;
  logic [WIDTH-1:0]  result_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_a
    debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (a[i]),
      .synced (a_sync_unused[i]),
      .stable (a_db[i])
    );
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_b
    debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (b[i]),
      .synced (b_sync_unused[i]),
      .stable (b_db[i])
    );
  end

  // Key synchroniser resets to "pressed" so a key held through reset is never seen released.
  debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1), .SYNC_RST_VAL(1'b0)) u_deb_key (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (key_n),
    .synced (key_sync),
    .stable (key_db)
  );

  debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (scan_en),
    .synced (scan_sync_unused),
    .stable (scan_db)
  );

  // Presses only count once the key has been observed released since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= 1'b1;
      armed <= 1'b0;
    end else begin
      key_q <= key_db;
      armed <= armed | (key_sync & key_db);
    end
  end

  assign press_c = armed & key_q & ~key_db;
  assign tick_c  = scan_db && (scan_cnt == SCAN_W'(SCAN_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (!scan_db || tick_c) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Coincident press and tick still advance the op by one.
  always_comb begin
    op_nxt_c = op;
    if (press_c || tick_c) begin
      op_nxt_c = op_e'(op + 3'd1);
    end
  end

  always_comb begin
    result_c = '0;
    case (op)
      OP_AND:  result_c = a_db & b_db;
      OP_NAND: result_c = ~(a_db & b_db);
      OP_OR:   result_c = a_db | b_db;
      OP_NOR:  result_c = ~(a_db | b_db);
      OP_XOR:  result_c = a_db ^ b_db;
      OP_XNOR: result_c = ~(a_db ^ b_db);
      OP_ADD:  result_c = a_db + b_db;
      OP_SUB:  result_c = a_db - b_db;
      default: result_c = '0;
    endcase
  end

  // op_led tracks the op register; led follows one cycle later from the registered op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= OP_AND;
      op_led <= '1;
      led    <= '1;
    end else begin
      op     <= op_nxt_c;
      op_led <= ~op_nxt_c;
      led    <= ~result_c;
    end
  end

endmodule

// File: tb/tb_logic_gate_lab.sv
// Directed bench for logic_gate_lab with a cycle-level reference model and literal spot checks.
module tb_logic_gate_lab;

  localparam int unsigned W    = 4;
  localparam int unsigned DEB  = 4;
  localparam int unsigned SCAN = 16;
  localparam int          NB   = 2 * W + 2;
  localparam int          KB   = 2 * W;
  localparam int          SB   = 2 * W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         key_n = 1'b1;
  logic         scan_en = 1'b0;
  logic [W-1:0] led;
  logic [2:0]   op_led;

  int total = 0;
  int bad   = 0;

  logic [2:0]   cur = 3'd0;
  logic [3:0]   sweep_exp [8] = '{4'h8, 4'h7, 4'hE, 4'h1, 4'h6, 4'h9, 4'h6, 4'h2};

  // reference model state
  logic [NB-1:0] m_p1, m_p2, m_stab;
  int            m_run [NB];
  logic          m_keyq, m_armed;
  int            m_scan;
  logic [2:0]    m_op;
  logic [W-1:0]  m_led;
  logic [2:0]    m_opled;

  logic_gate_lab #(.WIDTH(W), .DEB_CYCLES(DEB), .SCAN_CYCLES(SCAN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .key_n   (key_n),
    .scan_en (scan_en),
    .led     (led),
    .op_led  (op_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] op_res(input logic [2:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    int s;
    case (op)
      3'd0: return x & y;
      3'd1: return ~(x & y);
      3'd2: return x | y;
      3'd3: return ~(x | y);
      3'd4: return x ^ y;
      3'd5: return ~(x ^ y);
      3'd6: begin s = (int'(x) + int'(y)) % (1 << W); return W'(s); end
      default: begin s = (int'(x) - int'(y) + (1 << W)) % (1 << W); return W'(s); end
    endcase
  endfunction

  task automatic model_reset();
    m_p1   = '0;
    m_p2   = '0;
    m_stab = '0;
    m_stab[KB] = 1'b1;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    m_keyq  = 1'b1;
    m_armed = 1'b0;
    m_scan  = 0;
    m_op    = 3'd0;
    m_led   = '1;
    m_opled = 3'b111;
  endtask

  task automatic model_step();
    logic [NB-1:0] sv;
    logic press, tick;
    sv    = m_p2;
    m_p2  = m_p1;
    m_p1  = {scan_en, key_n, b, a};
    press = m_armed && m_keyq && !m_stab[KB];
    tick  = m_stab[SB] && (m_scan == int'(SCAN) - 1);
    m_led = ~op_res(m_op, m_stab[W-1:0], m_stab[2*W-1:W]);
    if (press || tick) m_op = m_op + 3'd1;
    m_opled = ~m_op;
    if (!m_stab[SB] || tick) m_scan = 0;
    else m_scan = m_scan + 1;
    m_keyq  = m_stab[KB];
    m_armed = m_armed | (sv[KB] & m_stab[KB]);
    for (int i = 0; i < NB; i++) begin
      if (sv[i] != m_stab[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(DEB)) begin
          m_stab[i] = sv[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_led", 8'(led), 8'(m_led));
      check("model_op_led", 8'(op_led), 8'(m_opled));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_op(input string name, input logic [2:0] op);
    logic [2:0] e;
    e = ~op;
    check(name, 8'(op_led), 8'(e));
  endtask

  task automatic check_led(input string name, input logic [3:0] res);
    logic [3:0] e;
    e = ~res;
    check(name, 8'(led), 8'(e));
  endtask

  task automatic press();
    key_n = 1'b0;
    cyc(8);
    key_n = 1'b1;
    cyc(8);
    cur = cur + 3'd1;
  endtask

  task automatic goto_op(input logic [2:0] target);
    for (int i = 0; i < 8; i++) begin
      if (cur != target) press();
    end
  endtask

  initial begin
    cyc(2);
    check("reset_led", 8'(led), 8'h0F);
    check("reset_op_led", 8'(op_led), 8'h07);

    rst_n = 1'b1;
    a = 4'b1100;
    b = 4'b1010;
    cyc(7);
    check_led("and_after_reset", 4'b1000);

    for (int k = 1; k < 8; k++) begin
      press();
      check_op("sweep_op", cur);
      check_led("sweep_led", sweep_exp[cur]);
    end
    press();
    check_op("wrap_op", 3'd0);
    check_led("wrap_led", 4'b1000);

    for (int i = 0; i < 10; i++) begin
      key_n = ~key_n;
      cyc(2);
    end
    check_op("bounce_none", cur);
    key_n = 1'b0;
    cyc(8);
    check_op("bounce_one", cur + 3'd1);
    key_n = 1'b1;
    cyc(8);
    cur = cur + 3'd1;

    a = 4'h5;
    cyc(3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_led", 8'(led), 8'h0F);
    check("midreset_op_led", 8'(op_led), 8'h07);
    @(negedge clk);
    rst_n = 1'b1;
    a = 4'b1100;
    b = 4'b1010;
    cur = 3'd0;
    cyc(7);
    check_led("and_after_midreset", 4'b1000);

    a = 4'hF;
    b = 4'h1;
    cyc(8);
    goto_op(3'd6);
    check_led("add_wrap", 4'h0);
    a = 4'h0;
    b = 4'h1;
    cyc(8);
    press();
    check_op("sub_op", 3'd7);
    check_led("sub_wrap", 4'hF);

    scan_en = 1'b1;
    cyc(40);
    check_op("scan_two_ticks", cur + 3'd2);
    cyc(7);
    key_n = 1'b0;
    cyc(10);
    check_op("scan_press_coincide", cur + 3'd3);
    key_n = 1'b1;
    scan_en = 1'b0;
    cyc(40);
    check_op("scan_frozen", cur + 3'd3);
    cur = cur + 3'd3;

    key_n = 1'b0;
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    check_op("held_key_reset", 3'd0);
    check_led("held_key_led", 4'h0);
    key_n = 1'b1;
    cyc(8);
    cur = 3'd0;
    press();
    check_op("press_after_release", 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
